// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port,
// a per-register busy scoreboard with a registered busy count,
// optional write-to-read bypass and optional hardwired-zero R0.
module regfile_scoreboard #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dst_id,
  input  logic [DATA_W-1:0] dst_in,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_id,
  input  logic [ADDR_W-1:0] src1_id,
  input  logic [ADDR_W-1:0] src2_id,
  output logic [DATA_W-1:0] src1_out,
  output logic [DATA_W-1:0] src2_out,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic              wr_eff;
  logic              rsv_eff;
  logic              cnt_inc;
  logic              cnt_dec;

  logic [ADDR_W-1:0] rd_id   [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  // Qualify write/reserve (R0 suppression) and compute next busy vector and count
  always_comb begin
    wr_eff  = wr_en  && !((ZERO_R0 != 0) && (dst_id == '0));
    rsv_eff = rsv_en && !((ZERO_R0 != 0) && (rsv_id == '0));
    busy_d  = busy_q;
    if (wr_eff) begin
      busy_d[dst_id] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[rsv_id] = 1'b1;
    end
    // Net change only: a reserve of a busy register or a write of an idle one
    // leaves the count alone; a write cancelled by a same-id reserve does not decrement.
    cnt_inc = rsv_eff && !busy_q[rsv_id];
    cnt_dec = wr_eff && busy_q[dst_id] && !(rsv_eff && (rsv_id == dst_id));
    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  // Register array, busy bits and busy count with async reset and sync clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (clr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_eff) begin
        regs_q[dst_id] <= dst_in;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports with optional bypass and hardwired-zero R0
  always_comb begin
    rd_id[0] = src1_id;
    rd_id[1] = src2_id;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_id[p]];
      rd_busy[p] = busy_q[rd_id[p]];
      if ((BYPASS != 0) && wr_en && (rd_id[p] == dst_id)) begin
        rd_data[p] = dst_in;
        // Same-cycle reserve is not forwarded, but it does cancel the forwarded clear.
        if (!(rsv_en && (rsv_id == dst_id))) begin
          rd_busy[p] = 1'b0;
        end
      end
      if ((ZERO_R0 != 0) && (rd_id[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign src1_out  = rd_data[0];
  assign src2_out  = rd_data[1];
  assign src1_busy = rd_busy[0];
  assign src2_busy = rd_busy[1];
  assign busy_cnt  = cnt_q;

endmodule
